// File: rtl/wb_arbiter_pkg.sv
// Shared types and helpers for the two-master Wishbone arbiter.
package wb_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } wb_arb_state_e;

    // Watchdog counter width; a disabled watchdog still yields a legal 1-bit width.
    function automatic int unsigned wb_arb_cnt_width(input int unsigned timeout_cycles);
        if (timeout_cycles == 0) begin
            return 1;
        end
        return $clog2(timeout_cycles + 1);
    endfunction

endpackage

// File: rtl/wb_arb_timer.sv
// Bus-timeout watchdog: counts stalled cycles and flags expiry at TIMEOUT_CYCLES.
module wb_arb_timer
    import wb_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic clk,
    input  logic rstn,
    input  logic run,
    input  logic clear,
    output logic expire
);

    localparam int unsigned CW = wb_arb_cnt_width(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);

    logic [CW-1:0] count;

    assign expire = (count == LIMIT);

    // Stall counter: clear wins, expiry restarts the count, otherwise count while running.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count <= '0;
        end else if (clear || expire) begin
            count <= '0;
        end else if (run) begin
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/wb_arbiter_2x1.sv
// Two-master, one-slave Wishbone arbiter: round-robin grant held for the whole
// CYC, combinational forwarding, and an optional per-access timeout watchdog.
module wb_arbiter_2x1
    import wb_arbiter_pkg::*;
#(
    parameter int unsigned WB_ADDR_WIDTH  = 32,
    parameter int unsigned WB_DATA_WIDTH  = 32,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic                         clk,
    input  logic                         rstn,
    // master 0
    input  logic [WB_ADDR_WIDTH-1:0]     m0_adr,
    input  logic [2:0]                   m0_cti,
    input  logic [1:0]                   m0_bte,
    input  logic [WB_DATA_WIDTH-1:0]     m0_dat_w,
    output logic [WB_DATA_WIDTH-1:0]     m0_dat_r,
    input  logic                         m0_cyc,
    output logic                         m0_err,
    input  logic [WB_DATA_WIDTH/8-1:0]   m0_sel,
    input  logic                         m0_stb,
    output logic                         m0_ack,
    input  logic                         m0_we,
    // master 1
    input  logic [WB_ADDR_WIDTH-1:0]     m1_adr,
    input  logic [2:0]                   m1_cti,
    input  logic [1:0]                   m1_bte,
    input  logic [WB_DATA_WIDTH-1:0]     m1_dat_w,
    output logic [WB_DATA_WIDTH-1:0]     m1_dat_r,
    input  logic                         m1_cyc,
    output logic                         m1_err,
    input  logic [WB_DATA_WIDTH/8-1:0]   m1_sel,
    input  logic                         m1_stb,
    output logic                         m1_ack,
    input  logic                         m1_we,
    // shared slave port
    output logic [WB_ADDR_WIDTH-1:0]     s0_adr,
    output logic [2:0]                   s0_cti,
    output logic [1:0]                   s0_bte,
    output logic [WB_DATA_WIDTH-1:0]     s0_dat_w,
    input  logic [WB_DATA_WIDTH-1:0]     s0_dat_r,
    output logic                         s0_cyc,
    input  logic                         s0_err,
    output logic [WB_DATA_WIDTH/8-1:0]   s0_sel,
    output logic                         s0_stb,
    input  logic                         s0_ack,
    output logic                         s0_we
);

    wb_arb_state_e state, state_next;
    logic          last_grant;
    logic          g_cyc, g_stb;
    logic          run, clear, expire, timeout;

    // Request qualifiers of whichever master currently owns the bus.
    assign g_cyc = (state == GNT0) ? m0_cyc : (state == GNT1) ? m1_cyc : 1'b0;
    assign g_stb = (state == GNT0) ? m0_stb : (state == GNT1) ? m1_stb : 1'b0;

    assign run     = g_cyc & g_stb & ~s0_ack & ~s0_err;
    assign clear   = ~run | (state_next != state);
    // A slave ACK landing on the expiry cycle takes precedence over the forced ERR.
    assign timeout = expire & g_cyc & g_stb & ~s0_ack;

    generate
        if (TIMEOUT_CYCLES != 0) begin : g_wdt
            wb_arb_timer #(
                .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
            ) u_timer (
                .clk   (clk),
                .rstn  (rstn),
                .run   (run),
                .clear (clear),
                .expire(expire)
            );
        end else begin : g_no_wdt
            assign expire = 1'b0;
        end
    endgenerate

    // State register and round-robin history.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= IDLE;
            last_grant <= 1'b1;
        end else begin
            state <= state_next;
            if (state_next == GNT0) begin
                last_grant <= 1'b0;
            end else if (state_next == GNT1) begin
                last_grant <= 1'b1;
            end
        end
    end

    // Grant decision: hold for the whole CYC, hand over directly on release.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (m0_cyc && m1_cyc) begin
                    state_next = last_grant ? GNT0 : GNT1;
                end else if (m0_cyc) begin
                    state_next = GNT0;
                end else if (m1_cyc) begin
                    state_next = GNT1;
                end
            end
            GNT0: if (!m0_cyc) state_next = m1_cyc ? GNT1 : IDLE;
            GNT1: if (!m1_cyc) state_next = m0_cyc ? GNT0 : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Forward the granted master to the slave and route responses back to it only.
    always_comb begin
        s0_adr   = '0;
        s0_cti   = '0;
        s0_bte   = '0;
        s0_dat_w = '0;
        s0_sel   = '0;
        s0_we    = 1'b0;
        s0_cyc   = 1'b0;
        s0_stb   = 1'b0;
        m0_ack   = 1'b0;
        m0_err   = 1'b0;
        m0_dat_r = '0;
        m1_ack   = 1'b0;
        m1_err   = 1'b0;
        m1_dat_r = '0;
        case (state)
            GNT0: begin
                s0_adr   = m0_adr;
                s0_cti   = m0_cti;
                s0_bte   = m0_bte;
                s0_dat_w = m0_dat_w;
                s0_sel   = m0_sel;
                s0_we    = m0_we;
                s0_cyc   = m0_cyc & ~timeout;
                s0_stb   = m0_stb & ~timeout;
                m0_ack   = s0_ack;
                m0_err   = s0_err | timeout;
                m0_dat_r = s0_dat_r;
            end
            GNT1: begin
                s0_adr   = m1_adr;
                s0_cti   = m1_cti;
                s0_bte   = m1_bte;
                s0_dat_w = m1_dat_w;
                s0_sel   = m1_sel;
                s0_we    = m1_we;
                s0_cyc   = m1_cyc & ~timeout;
                s0_stb   = m1_stb & ~timeout;
                m1_ack   = s0_ack;
                m1_err   = s0_err | timeout;
                m1_dat_r = s0_dat_r;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_wb_arbiter_2x1.sv
// Bench for wb_arbiter_2x1: two instances (watchdog 8 and watchdog disabled)
// share one set of directed stimulus; a cycle model checks both every cycle.
module tb_wb_arbiter_2x1;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    // shared master stimulus, index = master
    logic [31:0] m_adr[2];
    logic [31:0] m_dat_w[2];
    logic [2:0]  m_cti[2];
    logic [1:0]  m_bte[2];
    logic [3:0]  m_sel[2];
    logic        m_cyc[2];
    logic        m_stb[2];
    logic        m_we[2];
    // shared slave response stimulus
    logic        s_ack, s_err;
    logic [31:0] s_dat_r;

    // outputs, first index = dut (0: timeout 8, 1: timeout disabled)
    logic [31:0] o_s0_adr[2];
    logic [31:0] o_s0_dat_w[2];
    logic [2:0]  o_s0_cti[2];
    logic [1:0]  o_s0_bte[2];
    logic [3:0]  o_s0_sel[2];
    logic        o_s0_we[2];
    logic        o_s0_cyc[2];
    logic        o_s0_stb[2];
    logic        o_ack[2][2];
    logic        o_err[2][2];
    logic [31:0] o_dat_r[2][2];

    int n_checks = 0;
    int n_errors = 0;

    for (genvar d = 0; d < 2; d++) begin : g_dut
        wb_arbiter_2x1 #(
            .WB_ADDR_WIDTH (32),
            .WB_DATA_WIDTH (32),
            .TIMEOUT_CYCLES((d == 0) ? 8 : 0)
        ) u_dut (
            .clk     (clk),
            .rstn    (rstn),
            .m0_adr  (m_adr[0]),
            .m0_cti  (m_cti[0]),
            .m0_bte  (m_bte[0]),
            .m0_dat_w(m_dat_w[0]),
            .m0_dat_r(o_dat_r[d][0]),
            .m0_cyc  (m_cyc[0]),
            .m0_err  (o_err[d][0]),
            .m0_sel  (m_sel[0]),
            .m0_stb  (m_stb[0]),
            .m0_ack  (o_ack[d][0]),
            .m0_we   (m_we[0]),
            .m1_adr  (m_adr[1]),
            .m1_cti  (m_cti[1]),
            .m1_bte  (m_bte[1]),
            .m1_dat_w(m_dat_w[1]),
            .m1_dat_r(o_dat_r[d][1]),
            .m1_cyc  (m_cyc[1]),
            .m1_err  (o_err[d][1]),
            .m1_sel  (m_sel[1]),
            .m1_stb  (m_stb[1]),
            .m1_ack  (o_ack[d][1]),
            .m1_we   (m_we[1]),
            .s0_adr  (o_s0_adr[d]),
            .s0_cti  (o_s0_cti[d]),
            .s0_bte  (o_s0_bte[d]),
            .s0_dat_w(o_s0_dat_w[d]),
            .s0_dat_r(s_dat_r),
            .s0_cyc  (o_s0_cyc[d]),
            .s0_err  (s_err),
            .s0_sel  (o_s0_sel[d]),
            .s0_stb  (o_s0_stb[d]),
            .s0_ack  (s_ack),
            .s0_we   (o_s0_we[d])
        );
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // owner: -1 nobody, else master index; last: master granted most recently
    int owner[2];
    int last[2];
    int waited[2];

    function automatic int tmo(input int d);
        return (d == 0) ? 8 : 0;
    endfunction

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            logic [75:0] exp_s0, act_s0;
            logic [33:0] exp_m, act_m;
            logic        to;
            int          g;
            if (!rstn) begin
                owner[d]  = -1;
                last[d]   = 1;
                waited[d] = 0;
            end
            g  = owner[d];
            to = 1'b0;
            exp_s0 = '0;
            if (g >= 0) begin
                to = (tmo(d) != 0) && (waited[d] == tmo(d)) && m_cyc[g] && m_stb[g] && !s_ack;
                exp_s0 = {m_adr[g], m_cti[g], m_bte[g], m_dat_w[g], m_sel[g], m_we[g],
                          m_cyc[g] & ~to, m_stb[g] & ~to};
            end
            act_s0 = {o_s0_adr[d], o_s0_cti[d], o_s0_bte[d], o_s0_dat_w[d], o_s0_sel[d],
                      o_s0_we[d], o_s0_cyc[d], o_s0_stb[d]};
            check($sformatf("dut%0d_s0_bus", d), act_s0, exp_s0);
            for (int i = 0; i < 2; i++) begin
                exp_m = (g == i) ? {s_ack, s_err | to, s_dat_r} : 34'd0;
                act_m = {o_ack[d][i], o_err[d][i], o_dat_r[d][i]};
                check($sformatf("dut%0d_m%0d_resp", d, i), act_m, exp_m);
            end
            if (rstn) begin
                if (g < 0) begin
                    if (m_cyc[0] && m_cyc[1]) owner[d] = 1 - last[d];
                    else if (m_cyc[0])        owner[d] = 0;
                    else if (m_cyc[1])        owner[d] = 1;
                    waited[d] = 0;
                end else if (!m_cyc[g]) begin
                    owner[d]  = m_cyc[1 - g] ? 1 - g : -1;
                    waited[d] = 0;
                end else if (m_stb[g] && !s_ack && !s_err && !to) begin
                    waited[d]++;
                end else begin
                    waited[d] = 0;
                end
                if (owner[d] >= 0) last[d] = owner[d];
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_m(input int i, input logic [31:0] adr, input logic [31:0] dat,
                         input logic we, input logic [2:0] cti);
        m_adr[i]   = adr;
        m_dat_w[i] = dat;
        m_we[i]    = we;
        m_cti[i]   = cti;
        m_bte[i]   = 2'b00;
        m_sel[i]   = 4'hF;
        m_cyc[i]   = 1'b1;
        m_stb[i]   = 1'b1;
    endtask

    task automatic idle_m(input int i);
        m_adr[i]   = '0;
        m_dat_w[i] = '0;
        m_we[i]    = 1'b0;
        m_cti[i]   = '0;
        m_bte[i]   = '0;
        m_sel[i]   = '0;
        m_cyc[i]   = 1'b0;
        m_stb[i]   = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        int err_b, cyc_lo;
        rstn    = 1'b0;
        s_ack   = 1'b0;
        s_err   = 1'b0;
        s_dat_r = '0;
        idle_m(0);
        idle_m(1);
        repeat (3) @(posedge clk);
        #1;
        check("rst_s0_cyc", o_s0_cyc[0], 1'b0);
        rstn = 1'b1;

        // single m0 read, slave answers on the third granted cycle
        tick();
        set_m(0, 32'h1000, 32'h0, 1'b0, 3'b000);
        #1 check("t1_arb_latency", o_s0_cyc[0], 1'b0);
        tick();
        #1 check("t1_s0_cyc", o_s0_cyc[0], 1'b1);
        check("t1_s0_adr", o_s0_adr[0], 32'h1000);
        tick();
        tick();
        s_ack = 1'b1; s_dat_r = 32'hDEADBEEF;
        #1 check("t1_m0_ack", o_ack[0][0], 1'b1);
        check("t1_m0_dat", o_dat_r[0][0], 32'hDEADBEEF);
        check("t1_m1_ack", o_ack[0][1], 1'b0);
        check("t1_m1_dat", o_dat_r[0][1], 32'h0);
        tick();
        s_ack = 1'b0; s_dat_r = '0;
        idle_m(0);
        tick();

        // tie after reset, handover gap, then tie goes back to m0
        rstn = 1'b0;
        tick();
        tick();
        rstn = 1'b1;
        tick();
        set_m(0, 32'h2000, 32'h11, 1'b1, 3'b000);
        set_m(1, 32'h3000, 32'h22, 1'b1, 3'b000);
        tick();
        s_ack = 1'b1;
        #1 check("t2_first_tie_m0", o_s0_adr[0], 32'h2000);
        check("t2_m1_no_ack", o_ack[0][1], 1'b0);
        tick();
        s_ack = 1'b0;
        idle_m(0);
        #1 check("t2_handover_gap", o_s0_cyc[0], 1'b0);
        tick();
        #1 check("t2_m1_granted", o_s0_adr[0], 32'h3000);
        s_ack = 1'b1;
        #1 check("t2_m1_ack", o_ack[0][1], 1'b1);
        tick();
        s_ack = 1'b0;
        idle_m(1);
        tick();
        set_m(0, 32'h4000, 32'h0, 1'b0, 3'b000);
        set_m(1, 32'h5000, 32'h0, 1'b0, 3'b000);
        tick();
        #1 check("t2_second_tie_m0", o_s0_adr[0], 32'h4000);
        tick();
        idle_m(0);
        idle_m(1);
        tick();

        // m0 4-beat incrementing burst while m1 waits
        tick();
        set_m(0, 32'h6000, 32'h0, 1'b0, 3'b010);
        tick();
        set_m(1, 32'h7000, 32'h0, 1'b0, 3'b000);
        for (int b = 0; b < 4; b++) begin
            m_cti[0] = (b == 3) ? 3'b111 : 3'b010;
            m_adr[0] = 32'h6000 + 32'(4 * b);
            s_ack = 1'b1;
            #1 check($sformatf("t3_beat%0d_m0_ack", b), o_ack[0][0], 1'b1);
            check($sformatf("t3_beat%0d_m1_ack", b), o_ack[0][1], 1'b0);
            check($sformatf("t3_beat%0d_cti", b), o_s0_cti[0], (b == 3) ? 3'b111 : 3'b010);
            tick();
        end
        s_ack = 1'b0;
        idle_m(0);
        #1 check("t3_gap", o_s0_cyc[0], 1'b0);
        tick();
        #1 check("t3_m1_after", o_s0_adr[0], 32'h7000);
        s_ack = 1'b1;
        tick();
        s_ack = 1'b0;
        idle_m(1);
        tick();

        // m1 write to a dead slave: watchdog 8 fires 9 cycles after the request
        set_m(1, 32'h8000, 32'h55AA, 1'b1, 3'b000);
        #1 check("t4_not_yet", o_s0_cyc[0], 1'b0);
        tick();
        for (int i = 0; i < 8; i++) begin
            #1 check($sformatf("t4_wait%0d_err", i), o_err[0][1], 1'b0);
            check($sformatf("t4_wait%0d_cyc", i), o_s0_cyc[0], 1'b1);
            tick();
        end
        #1 check("t4_expire_err", o_err[0][1], 1'b1);
        check("t4_expire_ack", o_ack[0][1], 1'b0);
        check("t4_expire_cyc", o_s0_cyc[0], 1'b0);
        check("t4_expire_stb", o_s0_stb[0], 1'b0);
        check("t4_nowdt_err", o_err[1][1], 1'b0);
        check("t4_nowdt_cyc", o_s0_cyc[1], 1'b1);
        tick();
        #1 check("t4_pulse_end", o_err[0][1], 1'b0);
        check("t4_grant_kept", o_s0_cyc[0], 1'b1);
        repeat (8) tick();
        s_ack = 1'b1;
        #1 check("t4_ack_wins_ack", o_ack[0][1], 1'b1);
        check("t4_ack_wins_err", o_err[0][1], 1'b0);
        check("t4_ack_wins_cyc", o_s0_cyc[0], 1'b1);
        tick();
        s_ack = 1'b0;
        #1 check("t4_after_ack_err", o_err[0][1], 1'b0);
        idle_m(1);
        tick();

        // reset during an active m1 access
        set_m(1, 32'h9000, 32'h0, 1'b0, 3'b000);
        tick();
        #1 check("t5_m1_active", o_s0_cyc[0], 1'b1);
        #1 rstn = 1'b0;
        #1 check("t5_async_cyc0", o_s0_cyc[0], 1'b0);
        check("t5_async_cyc1", o_s0_cyc[1], 1'b0);
        check("t5_async_stb0", o_s0_stb[0], 1'b0);
        tick();
        rstn = 1'b1;
        set_m(0, 32'hA000, 32'h0, 1'b0, 3'b000);
        #1 check("t5_idle_after_rst", o_s0_cyc[0], 1'b0);
        tick();
        #1 check("t5_tie_m0", o_s0_adr[0], 32'hA000);
        tick();
        idle_m(0);
        idle_m(1);
        tick();

        // long stall: the disabled watchdog never errors and keeps the grant
        set_m(0, 32'hB000, 32'h0, 1'b0, 3'b000);
        tick();
        err_b  = 0;
        cyc_lo = 0;
        for (int i = 0; i < 1000; i++) begin
            #1;
            if (o_err[1][0] !== 1'b0) err_b++;
            if (o_s0_cyc[1] !== 1'b1) cyc_lo++;
            tick();
        end
        check("t6_no_err", err_b, 0);
        check("t6_grant_held", cyc_lo, 0);
        s_ack = 1'b1;
        #1 check("t6_final_ack", o_ack[1][0], 1'b1);
        tick();
        s_ack = 1'b0;
        idle_m(0);
        tick();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
